// File: rtl/smooth_line_ctrl_pkg.sv
// Shared definitions for the smoothing line controller: FSM encoding and
// the filter warm-up / flush constants.
package smooth_line_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } line_state_e;

    // Filter enables before its registered output holds a full 4-tap window.
    localparam int WARMUP           = 5;
    // Replicas of the last sample pushed in to finish a line.
    localparam int FLUSH_N          = 4;
    localparam int DEFAULT_MAX_LINE = 1024;

endpackage

// File: rtl/smooth_line_ctrl.sv
// Line sequencer for an external 4-tap smoothing filter: feeds samples, flushes
// each line with replicas of its last sample and frames the smoothed output.
module smooth_line_ctrl
    import smooth_line_ctrl_pkg::*;
#(
    parameter int MAX_LINE = DEFAULT_MAX_LINE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        filt_clear,
    output logic        filt_enb,
    output logic [7:0]  filt_din,
    input  logic [7:0]  filt_dout,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [7:0]  m_data,
    output logic        m_last,
    output logic        err_overlen,
    output line_state_e dbg_state
);

    localparam logic [9:0] LAST_IDX   = 10'(MAX_LINE - 1);
    localparam logic [2:0] ENB_SAT    = 3'(WARMUP);
    localparam logic [2:0] ENB_QUAL   = 3'(WARMUP - 1);
    localparam logic [1:0] FLUSH_LAST = 2'(FLUSH_N - 1);

    line_state_e state, state_next;
    logic [9:0]  sample_cnt;
    logic [2:0]  enb_cnt;
    logic [1:0]  flush_cnt;
    logic [7:0]  last_sample;
    logic        m_valid_q;
    logic        m_last_q;
    logic        err_q;
    logic        clear_q;

    logic out_free;
    logic accept;
    logic flush_enb;
    logic line_full;
    logic qual_enb;
    logic flush_done;
    logic out_hs;

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // The filter only advances when the output register is empty or being
    // emptied this cycle, so a held m_valid freezes both input and filter.
    always_comb begin
        out_free   = !m_valid_q || m_ready;
        out_hs     = m_valid_q && m_ready;
        s_ready    = (state == ST_RUN) && out_free;
        accept     = s_valid && s_ready;
        flush_enb  = (state == ST_FLUSH) && out_free;
        filt_enb   = accept || flush_enb;
        filt_din   = accept ? s_data : last_sample;
        line_full  = accept && !s_last && (sample_cnt == LAST_IDX);
        qual_enb   = filt_enb && (enb_cnt >= ENB_QUAL);
        flush_done = flush_enb && (flush_cnt == FLUSH_LAST);
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_CLEAR: state_next = ST_RUN;
            ST_RUN:   if (accept && (s_last || line_full)) state_next = ST_FLUSH;
            ST_FLUSH: if (flush_done) state_next = ST_DRAIN;
            ST_DRAIN: if (out_hs && m_last_q) state_next = ST_CLEAR;
            default:  state_next = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_CLEAR;
            sample_cnt  <= '0;
            enb_cnt     <= '0;
            flush_cnt   <= '0;
            last_sample <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            err_q       <= 1'b0;
            clear_q     <= 1'b1;
        end else begin
            state   <= state_next;
            clear_q <= (state_next == ST_CLEAR);

            if (state == ST_CLEAR) begin
                sample_cnt <= '0;
                enb_cnt    <= '0;
                flush_cnt  <= '0;
            end else begin
                if (accept) begin
                    sample_cnt  <= sample_cnt + 10'd1;
                    last_sample <= s_data;
                end
                if (filt_enb && (enb_cnt != ENB_SAT)) enb_cnt <= enb_cnt + 3'd1;
                if (flush_enb) flush_cnt <= flush_cnt + 2'd1;
            end

            // A qualifying enable refills the output even while it is being taken.
            if (qual_enb) begin
                m_valid_q <= 1'b1;
                m_last_q  <= flush_done;
            end else if (out_hs) begin
                m_valid_q <= 1'b0;
                m_last_q  <= 1'b0;
            end

            if (line_full) err_q <= 1'b1;
        end
    end

    assign filt_clear  = clear_q;
    assign m_valid     = m_valid_q;
    assign m_last      = m_last_q;
    assign m_data      = filt_dout;
    assign err_overlen = err_q;
    assign dbg_state   = state;

endmodule

// File: tb/tb_smooth_line_ctrl.sv
// Directed bench for smooth_line_ctrl with a behavioural 4-tap smoothing filter
// attached as the sibling block.
module tb_smooth_line_ctrl;
  import smooth_line_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid, s_ready, s_last;
  logic [7:0]  s_data;
  logic        filt_clear, filt_enb;
  logic [7:0]  filt_din, filt_dout;
  logic        m_valid, m_ready, m_last;
  logic [7:0]  m_data;
  logic        err_overlen;
  line_state_e dbg_state;

  int tests = 0;
  int fails = 0;

  logic [7:0] out_q[$];
  logic       last_q[$];
  int         enb_seen;
  int         stall_viol;
  bit         rdy_mode = 1'b0;
  int         pat_i = 0;
  logic [7:0] taps[4];

  always #5 clk = ~clk;

  smooth_line_ctrl #(.MAX_LINE(8)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .filt_clear(filt_clear), .filt_enb(filt_enb), .filt_din(filt_din), .filt_dout(filt_dout),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .err_overlen(err_overlen), .dbg_state(dbg_state)
  );

  // Sibling filter: registered sum of (x>>2) over the four taps held before this enable.
  always @(posedge clk) begin
    if (filt_clear) begin
      for (int i = 0; i < 4; i++) taps[i] <= 8'd0;
      filt_dout <= 8'd0;
    end else if (filt_enb) begin
      filt_dout <= (taps[0] >> 2) + (taps[1] >> 2) + (taps[2] >> 2) + (taps[3] >> 2);
      taps[0] <= filt_din;
      taps[1] <= taps[0];
      taps[2] <= taps[1];
      taps[3] <= taps[2];
    end
  end

  // Downstream ready: constant 1, or the repeating 1,0,0 pattern.
  always @(negedge clk) begin
    if (rdy_mode) begin
      m_ready = (pat_i % 3 == 0);
      pat_i++;
    end else begin
      m_ready = 1'b1;
    end
  end

  // Monitor: inputs settle at the falling edge, so values here are those the next rising edge sees.
  always begin
    @(negedge clk);
    #2;
    if (!reset) begin
      if (m_valid && m_ready) begin
        out_q.push_back(m_data);
        last_q.push_back(m_last);
      end
      if (filt_enb) enb_seen++;
      if (m_valid && !m_ready && (filt_enb || s_ready)) stall_viol++;
    end
  end

  task automatic send(input logic [7:0] d, input logic l);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < 200) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      #1;
      if (s_ready) begin
        @(posedge clk);
        done = 1'b1;
      end
      n++;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL send_timeout data=%0d s_ready=0 required=1", d);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int c = 0;
    while (out_q.size() < n && c < 400) begin
      @(negedge clk);
      c++;
    end
    if (out_q.size() < n) begin
      tests++; fails++;
      $display("FAIL out_timeout got=%0d required=%0d", out_q.size(), n);
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic clear_obs();
    out_q.delete();
    last_q.delete();
    enb_seen   = 0;
    stall_viol = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    tests++; if (dbg_state !== ST_CLEAR) begin fails++; $display("FAIL rst_state got=%0d required=%0d", dbg_state, ST_CLEAR); end
    tests++; if (filt_clear !== 1'b1) begin fails++; $display("FAIL rst_filt_clear got=%b required=1", filt_clear); end
    tests++; if (filt_enb !== 1'b0) begin fails++; $display("FAIL rst_filt_enb got=%b required=0", filt_enb); end
    tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL rst_s_ready got=%b required=0", s_ready); end
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL rst_m_valid got=%b required=0", m_valid); end
    tests++; if (m_last !== 1'b0) begin fails++; $display("FAIL rst_m_last got=%b required=0", m_last); end
    tests++; if (err_overlen !== 1'b0) begin fails++; $display("FAIL rst_err got=%b required=0", err_overlen); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic_line(input string tag);
    logic [7:0] exp_v[4];
    exp_v = '{8'd100, 8'd130, 8'd150, 8'd160};
    clear_obs();
    send(8'd40, 1'b0); send(8'd80, 1'b0); send(8'd120, 1'b0); send(8'd160, 1'b1);
    idle();
    wait_out(4);
    tests++; if (out_q.size() !== 4) begin fails++; $display("FAIL %s_count got=%0d required=4", tag, out_q.size()); end
    for (int k = 0; k < 4; k++) begin
      if (k < out_q.size()) begin
        tests++; if (out_q[k] !== exp_v[k]) begin fails++; $display("FAIL %s_data[%0d] got=%0d required=%0d", tag, k, out_q[k], exp_v[k]); end
        tests++; if (last_q[k] !== (k == 3)) begin fails++; $display("FAIL %s_last[%0d] got=%b required=%b", tag, k, last_q[k], k == 3); end
      end
    end
    tests++; if (enb_seen !== 8) begin fails++; $display("FAIL %s_enables got=%0d required=8", tag, enb_seen); end
    tests++; if (stall_viol !== 0) begin fails++; $display("FAIL %s_stall got=%0d required=0", tag, stall_viol); end
  endtask

  task automatic test_line();
    test_basic_line("line");
    tests++; if (err_overlen !== 1'b0) begin fails++; $display("FAIL line_err got=%b required=0", err_overlen); end
    tests++; if (dbg_state !== ST_RUN) begin fails++; $display("FAIL line_state got=%0d required=%0d", dbg_state, ST_RUN); end
  endtask

  task automatic test_single();
    clear_obs();
    send(8'd200, 1'b1);
    idle();
    wait_out(1);
    tests++; if (out_q.size() !== 1) begin fails++; $display("FAIL single_count got=%0d required=1", out_q.size()); end
    if (out_q.size() > 0) begin
      tests++; if (out_q[0] !== 8'd200) begin fails++; $display("FAIL single_data got=%0d required=200", out_q[0]); end
      tests++; if (last_q[0] !== 1'b1) begin fails++; $display("FAIL single_last got=%b required=1", last_q[0]); end
    end
    tests++; if (enb_seen !== 5) begin fails++; $display("FAIL single_enables got=%0d required=5", enb_seen); end
  endtask

  task automatic test_stall();
    pat_i = 0;
    rdy_mode = 1'b1;
    test_basic_line("stall");
    rdy_mode = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_overlen();
    logic [7:0] exp_v[11];
    logic       exp_l[11];
    exp_v = '{8'd10, 8'd14, 8'd18, 8'd22, 8'd26, 8'd29, 8'd31, 8'd32, 8'd41, 8'd43, 8'd44};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    clear_obs();
    for (int i = 1; i <= 10; i++) send(8'(4 * i), 1'b0);
    send(8'd44, 1'b1);
    idle();
    wait_out(11);
    tests++; if (out_q.size() !== 11) begin fails++; $display("FAIL ovl_count got=%0d required=11", out_q.size()); end
    for (int k = 0; k < 11; k++) begin
      if (k < out_q.size()) begin
        tests++; if (out_q[k] !== exp_v[k]) begin fails++; $display("FAIL ovl_data[%0d] got=%0d required=%0d", k, out_q[k], exp_v[k]); end
        tests++; if (last_q[k] !== exp_l[k]) begin fails++; $display("FAIL ovl_last[%0d] got=%b required=%b", k, last_q[k], exp_l[k]); end
      end
    end
    tests++; if (err_overlen !== 1'b1) begin fails++; $display("FAIL ovl_err got=%b required=1", err_overlen); end
  endtask

  task automatic test_reset_mid();
    clear_obs();
    send(8'd40, 1'b0); send(8'd80, 1'b0); send(8'd120, 1'b0);
    idle();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    tests++; if (filt_clear !== 1'b1) begin fails++; $display("FAIL mid_filt_clear got=%b required=1", filt_clear); end
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL mid_m_valid got=%b required=0", m_valid); end
    tests++; if (err_overlen !== 1'b0) begin fails++; $display("FAIL mid_err got=%b required=0", err_overlen); end
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    tests++; if (out_q.size() !== 0) begin fails++; $display("FAIL mid_no_output got=%0d required=0", out_q.size()); end
    test_basic_line("mid");
  endtask

  initial begin
    reset   = 1'b1;
    s_valid = 1'b0;
    s_data  = 8'd0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    test_reset();
    test_line();
    test_single();
    test_stall();
    test_overlen();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/smooth_line_ctrl.md
SMOOTH_LINE_CTRL -- requirements
Module: smooth_line_ctrl

Interface
REQ-001 Parameter MAX_LINE, default 1024: maximum samples per line before a forced line end.
REQ-002 Port clk, input, 1: single clock; all logic SHALL be on its rising edge.
REQ-003 Port reset, input, 1: synchronous, active-high reset.
REQ-004 Port s_valid, input, 1: upstream sample valid.
REQ-005 Port s_ready, output, 1: block accepts the sample this cycle.
REQ-006 Port s_data, input, 8: unsigned pixel sample.
REQ-007 Port s_last, input, 1: qualifies the final sample of a line.
REQ-008 Port filt_clear, output, 1: registered, drives the smoothing filter reset input.
REQ-009 Port filt_enb, output, 1: smoothing filter enable.
REQ-010 Port filt_din, output, 8: smoothing filter input sample.
REQ-011 Port filt_dout, input, 8: smoothing filter registered output.
REQ-012 Port m_valid, output, 1: smoothed sample valid.
REQ-013 Port m_ready, input, 1: downstream accepts.
REQ-014 Port m_data, output, 8: equals filt_dout combinationally.
REQ-015 Port m_last, output, 1: qualifies the final smoothed sample of a line.
REQ-016 Port err_overlen, output, 1: sticky flag set on a forced line end.

Function
REQ-017 The block SHALL implement a four-state FSM: CLEAR, RUN, FLUSH and DRAIN.
REQ-018 CLEAR SHALL last one cycle with filt_clear=1, zero the counters, then go to RUN.
REQ-019 In RUN, s_ready SHALL be 1 iff (!m_valid || m_ready); in all other states, s_ready SHALL be 0.
REQ-020 In RUN, an accepted sample (s_valid && s_ready) SHALL assert filt_enb the same cycle with filt_din = s_data, and SHALL register s_data as last_sample.
REQ-021 An accepted sample with s_last=1 SHALL transition the FSM to FLUSH.
REQ-022 In FLUSH, filt_enb SHALL assert on each cycle where (!m_valid || m_ready), with filt_din = last_sample, for exactly 4 enables; the FSM SHALL then go to DRAIN.
REQ-023 enb_cnt (3 bits) SHALL count filter enables per line and saturate at 5; m_valid SHALL be set in the cycle after any enable that brings enb_cnt to 5 or finds it already at 5.
REQ-024 m_valid SHALL clear on handshake (m_valid && m_ready) unless a new qualifying enable occurs in the same cycle, in which case it SHALL stay 1.
REQ-025 The block SHALL emit exactly N outputs for a line of N ≥ 1 input samples; output k SHALL be the sum of (x>>2) over inputs k..k+3, with flush replicas substituted past N.
REQ-026 m_last SHALL be 1 with the output produced by the 4th flush enable, and SHALL clear on its handshake.
REQ-027 DRAIN SHALL wait for the m_last handshake, then go to CLEAR; no input SHALL be accepted until the next RUN.
REQ-028 A 10-bit sample counter SHALL count accepted samples; accepting sample MAX_LINE with s_last=0 SHALL go to FLUSH and set err_overlen, with subsequent samples starting the next line.
REQ-029 Whenever m_valid=1 and m_ready=0, the block SHALL stall: filt_enb=0 and s_ready=0, with filt_dout held.

Reset
REQ-030 While reset=1: the FSM SHALL be in CLEAR, filt_clear=1, filt_enb=0, s_ready=0, m_valid=0, m_last=0, err_overlen=0, and all counters and last_sample SHALL be 0.
REQ-031 Reset asserted mid-line SHALL abandon the line with no output; the first post-reset sample SHALL start a new line.
REQ-032 err_overlen SHALL clear only on reset.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding and the constants WARMUP=5, FLUSH_N=4 and the default MAX_LINE.
REQ-034 No sub-module is required: the smoothing filter SHALL be instantiated as a sibling at the level above, not inside this block.

Verification
REQ-035 Inputs 40,80,120,160 (last on 160), m_ready=1 -> outputs 100,130,150,160, m_last on 160, exactly 4 outputs.
REQ-036 A single sample of 200 with last=1 -> exactly one output of 200 with m_last=1.
REQ-037 The REQ-035 line with m_ready toggled 1,0,0,1,... -> identical values and order, no filt_enb while stalled, and no drop or duplicate.
REQ-038 MAX_LINE=8 with 10 samples and no s_last -> 8 outputs ending in m_last, err_overlen=1, and samples 9-10 starting a new line.
REQ-039 Reset pulsed after the 3rd sample -> no m_valid, filt_clear=1 during reset, and a following 4-sample line reproducing the REQ-035 results.
